wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take the port directly, load
// results wait in a small in-order queue and drain whenever the ALU is not writing.
// Latency: the selected write appears on Wen/WAddr/WData one rising edge later.
// Backpressure: mem_ready drops when the queue is full; alu_stall rises when the
// queue is full or a queued load targets the same register (upstream holds alu_*).
//
// Ports:
//   Clock, Reset                        rising-edge clock, synchronous active-low reset
//   alu_valid/alu_waddr/alu_wdata       ALU result in, alu_stall out
//   mem_valid/mem_waddr/mem_wdata       load result in, mem_ready out
//   Wen/WAddr/WData                     registered register-file write port

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef RSIZE
`define RSIZE 4
`endif

module wb_arbiter #(
    parameter int DSIZE = `DSIZE,
    parameter int RSIZE = `RSIZE,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             alu_valid,
    input  logic [RSIZE-1:0] alu_waddr,
    input  logic [DSIZE-1:0] alu_wdata,
    output logic             alu_stall,
    input  logic             mem_valid,
    input  logic [RSIZE-1:0] mem_waddr,
    input  logic [DSIZE-1:0] mem_wdata,
    output logic             mem_ready,
    output logic             Wen,
    output logic [RSIZE-1:0] WAddr,
    output logic [DSIZE-1:0] WData
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Queue storage; vld_q marks occupied slots so the hazard compare only
    // looks at live entries without pointer arithmetic.
    logic [RSIZE-1:0] addr_q [DEPTH];
    logic [RSIZE-1:0] addr_d [DEPTH];
    logic [DSIZE-1:0] data_q [DEPTH];
    logic [DSIZE-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             wen_q, wen_d;
    logic [RSIZE-1:0] waddr_q, waddr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;

    logic full, match, alu_win, push, pop;

    always_comb begin
        full  = (count_q == FULL);
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == alu_waddr)) begin
                match = 1'b1;
            end
        end

        // Stalling on a full queue guarantees the head drains that cycle.
        alu_stall = Reset && alu_valid && (full || ((alu_waddr != '0) && match));
        mem_ready = Reset && (count_q < FULL);

        // r0 writes are dropped on acceptance and never claim the port.
        alu_win = alu_valid && !alu_stall && (alu_waddr != '0);
        push    = mem_valid && mem_ready && (mem_waddr != '0);
        pop     = !alu_win && (count_q != '0);

        addr_d   = addr_q;
        data_d   = data_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        if (alu_win) begin
            wen_d   = 1'b1;
            waddr_d = alu_waddr;
            wdata_d = alu_wdata;
        end else if (pop) begin
            wen_d           = 1'b1;
            waddr_d         = addr_q[rd_ptr_q];
            wdata_d         = data_q[rd_ptr_q];
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        // Push never lands on the slot being popped: a pop needs count > 0 and
        // a push needs count < DEPTH, so the pointers differ whenever both fire.
        if (push) begin
            addr_d[wr_ptr_q] = mem_waddr;
            data_d[wr_ptr_q] = mem_wdata;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign Wen   = wen_q;
    assign WAddr = waddr_q;
    assign WData = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int DS    = 16;
    localparam int RS    = 4;
    localparam int DEPTH = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic [RS-1:0] alu_waddr = '0;
    logic [DS-1:0] alu_wdata = '0;
    logic          alu_stall;
    logic          mem_valid = 1'b0;
    logic [RS-1:0] mem_waddr = '0;
    logic [DS-1:0] mem_wdata = '0;
    logic          mem_ready;
    logic          Wen;
    logic [RS-1:0] WAddr;
    logic [DS-1:0] WData;

    int tests = 0;
    int fails = 0;

    wb_arbiter #(.DSIZE(DS), .RSIZE(RS), .DEPTH(DEPTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .alu_valid (alu_valid),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .alu_stall (alu_stall),
        .mem_valid (mem_valid),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .Wen       (Wen),
        .WAddr     (WAddr),
        .WData     (WData)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a plain queue of pending loads plus the expected
    // contents of the write port. Advanced once per cycle from the inputs
    // that will be sampled at the coming rising edge.
    // ---------------------------------------------------------------------
    typedef struct {
        logic [RS-1:0] a;
        logic [DS-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          e_wen   = 1'b0;
    logic [RS-1:0] e_waddr = '0;
    logic [DS-1:0] e_wdata = '0;
    bit            exp_known = 1'b0;

    initial begin : compare
        bit   full, haz, win, pop, hit;
        ent_t e;
        forever begin
            @(negedge Clock);
            #2;
            full = (mq.size() == DEPTH);
            hit  = 1'b0;
            foreach (mq[i]) if (mq[i].a == alu_waddr) hit = 1'b1;
            haz  = alu_valid && (full || (alu_waddr != 0 && hit));

            if (!Reset) begin
                chk("mdl.rst_mem_ready", 32'(mem_ready), 32'(0));
                chk("mdl.rst_alu_stall", 32'(alu_stall), 32'(0));
            end else begin
                chk("mdl.mem_ready", 32'(mem_ready), 32'(!full));
                chk("mdl.alu_stall", 32'(alu_stall), 32'(haz));
            end
            if (exp_known) begin
                chk("mdl.Wen", 32'(Wen), 32'(e_wen));
                chk("mdl.WAddr", 32'(WAddr), 32'(e_waddr));
                chk("mdl.WData", 32'(WData), 32'(e_wdata));
            end

            if (!Reset) begin
                mq.delete();
                e_wen     = 1'b0;
                e_waddr   = '0;
                e_wdata   = '0;
                exp_known = 1'b1;
            end else begin
                win = alu_valid && !haz && (alu_waddr != 0);
                pop = !win && (mq.size() > 0);
                if (win) begin
                    e_wen = 1'b1; e_waddr = alu_waddr; e_wdata = alu_wdata;
                end else if (pop) begin
                    e = mq.pop_front();
                    e_wen = 1'b1; e_waddr = e.a; e_wdata = e.d;
                end else begin
                    e_wen = 1'b0;
                end
                if (mem_valid && !full && mem_waddr != 0) begin
                    e.a = mem_waddr;
                    e.d = mem_wdata;
                    mq.push_back(e);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    bit stall_seen = 1'b0;

    task automatic step(input logic av, input logic [RS-1:0] aa, input logic [DS-1:0] ad,
                        input logic mv, input logic [RS-1:0] ma, input logic [DS-1:0] md,
                        input logic rst);
        @(negedge Clock);
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        mem_valid = mv; mem_waddr = ma; mem_wdata = md;
        Reset     = rst;
        #1;
        stall_seen = alu_stall;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic port(input string tag, input logic w, input logic [RS-1:0] a,
                        input logic [DS-1:0] d);
        @(posedge Clock);
        #1;
        chk({tag, ".Wen"}, 32'(Wen), 32'(w));
        chk({tag, ".WAddr"}, 32'(WAddr), 32'(a));
        chk({tag, ".WData"}, 32'(WData), 32'(d));
    endtask

    logic [RS-1:0] hz_a [4];
    logic [DS-1:0] hz_d [4];

    initial begin
        // Reset state with inputs active: everything must be ignored.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'd5, 16'h5555, 1'b1, 4'd5, 16'h5555, 1'b0);
            chk("rst.mem_ready", 32'(mem_ready), 32'(0));
            chk("rst.alu_stall", 32'(alu_stall), 32'(0));
            port("rst", 1'b0, 4'd0, 16'h0000);
        end

        // ALU only.
        step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b1);
        chk("alu.stall", 32'(alu_stall), 32'(0));
        chk("alu.mem_ready", 32'(mem_ready), 32'(1));
        port("alu", 1'b1, 4'd3, 16'h1234);

        // Simultaneous ALU and load: ALU first, load on the next edge.
        step(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b1);
        port("sim1", 1'b1, 4'd5, 16'hAAAA);
        idle();
        port("sim2", 1'b1, 4'd6, 16'hBBBB);
        idle();
        port("sim_idle", 1'b0, 4'd6, 16'hBBBB);

        // Fill the queue with r1..r4 while the ALU writes r7..r10.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, RS'(7 + i), DS'(16'h7000 + i), 1'b1, RS'(1 + i), DS'(16'h1000 + i), 1'b1);
            port("fill_alu", 1'b1, RS'(7 + i), DS'(16'h7000 + i));
        end
        step(1'b1, 4'd11, 16'hB0B0, 1'b1, 4'd12, 16'hC0C0, 1'b1);
        chk("full.mem_ready", 32'(mem_ready), 32'(0));
        chk("full.alu_stall", 32'(alu_stall), 32'(1));
        port("full.pop", 1'b1, 4'd1, 16'h1000);
        step(1'b1, 4'd11, 16'hB0B0, 1'b0, 4'd0, 16'h0, 1'b1);
        chk("full.ready_back", 32'(mem_ready), 32'(1));
        chk("full.stall_clear", 32'(alu_stall), 32'(0));
        port("full.alu", 1'b1, 4'd11, 16'hB0B0);
        for (int i = 0; i < 3; i++) begin
            idle();
            port("full.drain", 1'b1, RS'(2 + i), DS'(16'h1001 + i));
        end

        // Hazard: load r9 queued behind r1 and r5, then ALU r9.
        step(1'b1, 4'd2, 16'h2020, 1'b1, 4'd1, 16'h0101, 1'b1);
        port("hz.fill", 1'b1, 4'd2, 16'h2020);
        step(1'b1, 4'd3, 16'h3030, 1'b1, 4'd5, 16'h0505, 1'b1);
        port("hz.fill", 1'b1, 4'd3, 16'h3030);
        step(1'b1, 4'd4, 16'h4040, 1'b1, 4'd9, 16'h0909, 1'b1);
        port("hz.fill", 1'b1, 4'd4, 16'h4040);
        hz_a[0] = 4'd1; hz_a[1] = 4'd5; hz_a[2] = 4'd9; hz_a[3] = 4'd9;
        hz_d[0] = 16'h0101; hz_d[1] = 16'h0505; hz_d[2] = 16'h0909; hz_d[3] = 16'h9999;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h0, 1'b1);
            chk("hz.stall", 32'(alu_stall), (k < 3) ? 32'd1 : 32'd0);
            port("hz.order", 1'b1, hz_a[k], hz_d[k]);
        end

        // Zero register: r0 ALU and r0 load are dropped, queued head still pops.
        step(1'b1, 4'd2, 16'h2222, 1'b1, 4'd3, 16'h3333, 1'b1);
        port("r0.setup", 1'b1, 4'd2, 16'h2222);
        step(1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd0, 16'hBEEF, 1'b1);
        chk("r0.stall", 32'(alu_stall), 32'(0));
        port("r0.pop", 1'b1, 4'd3, 16'h3333);
        step(1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd0, 16'hBEEF, 1'b1);
        chk("r0.mem_ready", 32'(mem_ready), 32'(1));
        port("r0.none", 1'b0, 4'd3, 16'h3333);

        // Reset with three queued entries: nothing of them is ever written.
        step(1'b1, 4'd2, 16'h2A2A, 1'b1, 4'd4, 16'h4444, 1'b1);
        step(1'b1, 4'd3, 16'h3B3B, 1'b1, 4'd5, 16'h5555, 1'b1);
        step(1'b1, 4'd6, 16'h6C6C, 1'b1, 4'd7, 16'h7777, 1'b1);
        port("mid.fill", 1'b1, 4'd6, 16'h6C6C);
        step(1'b1, 4'd8, 16'h8888, 1'b1, 4'd8, 16'h8888, 1'b0);
        chk("mid.rst_ready", 32'(mem_ready), 32'(0));
        chk("mid.rst_stall", 32'(alu_stall), 32'(0));
        port("mid.rst", 1'b0, 4'd0, 16'h0000);
        idle();
        chk("mid.ready", 32'(mem_ready), 32'(1));
        port("mid.after1", 1'b0, 4'd0, 16'h0000);
        idle();
        port("mid.after2", 1'b0, 4'd0, 16'h0000);

        // Random traffic against the model; narrow address range for hazards.
        for (int n = 0; n < 3000; n++) begin
            logic          av, mv, rs;
            logic [RS-1:0] aa, ma;
            logic [DS-1:0] ad, md;
            if (alu_valid && stall_seen) begin
                av = alu_valid; aa = alu_waddr; ad = alu_wdata;
            end else begin
                av = ($urandom_range(0, 3) != 0);
                aa = RS'($urandom_range(0, 7));
                ad = DS'($urandom);
            end
            mv = ($urandom_range(0, 2) != 0);
            ma = RS'($urandom_range(0, 7));
            md = DS'($urandom);
            rs = ($urandom_range(0, 149) != 0);
            step(av, aa, ad, mv, ma, md, rs);
        end
        idle();
        idle();
        @(posedge Clock);
        #3;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
